// File: rtl/usb_desc_reader.sv
`default_nettype none
// usb_desc_reader: streams GET_DESCRIPTOR data from the descriptor ROM to the EP0 IN engine.
// Optional macro USB_DESC_RETRY_EN: NAK in WAIT_ACK rewinds and resends the current packet.
module usb_desc_reader #(
   parameter int MAXPKT   = 64,
   parameter int LANG_LEN = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [7:0]  i_desc_type,
   input  logic [7:0]  i_desc_index,
   input  logic [15:0] i_wlength,
   input  logic        i_hs_mode,
   input  logic        i_abort,
   input  logic [9:0]  i_desc_dev_addr,
   input  logic [7:0]  i_desc_dev_len,
   input  logic [9:0]  i_desc_qual_addr,
   input  logic [7:0]  i_desc_qual_len,
   input  logic [9:0]  i_desc_fscfg_addr,
   input  logic [7:0]  i_desc_fscfg_len,
   input  logic [9:0]  i_desc_hscfg_addr,
   input  logic [7:0]  i_desc_hscfg_len,
   input  logic [9:0]  i_desc_strlang_addr,
   input  logic [9:0]  i_desc_strvendor_addr,
   input  logic [7:0]  i_desc_strvendor_len,
   input  logic [9:0]  i_desc_strproduct_addr,
   input  logic [7:0]  i_desc_strproduct_len,
   input  logic [9:0]  i_desc_strserial_addr,
   input  logic [7:0]  i_desc_strserial_len,
   input  logic        i_descrom_have_strings,
   output logic [9:0]  o_descrom_raddr,
   input  logic [7:0]  i_descrom_rdat,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_valid,
   input  logic        i_tx_ready,
   output logic        o_tx_last,
   output logic        o_tx_zlp,
   input  logic        i_pkt_ack,
   input  logic        i_pkt_nak,
   output logic        o_stall,
   output logic        o_busy
);

   localparam int PKT_W = $clog2(MAXPKT);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOOKUP   = 3'd1,
      S_SEND     = 3'd2,
      S_WAIT_ACK = 3'd3,
      S_ZLP      = 3'd4,
      S_ZLP_WAIT = 3'd5,
      S_STALL    = 3'd6
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [7:0]       req_type;
   logic [7:0]       req_index;
   logic [15:0]      req_wlength;
   logic             req_hs;

   logic [9:0]       ptr;
   logic [15:0]      sent;
   logic [15:0]      total;
   logic [PKT_W-1:0] pkt_cnt;
   logic             patch;

`ifdef USB_DESC_RETRY_EN
   logic [9:0]       save_ptr;
   logic [15:0]      save_sent;
`else
   logic             nak_unused;
   assign nak_unused = i_pkt_nak;
`endif

   logic             lk_hit;
   logic [9:0]       lk_addr;
   logic [7:0]       lk_len;
   logic             lk_patch;
   logic             lk_ok;
   logic [15:0]      lk_len16;
   logic [15:0]      lk_total;

   logic             fire;
   logic             last_byte;
   logic             more;
   logic             zlp_needed;

   // Resolve the latched request to a ROM window.
   always_comb begin
      lk_hit   = 1'b0;
      lk_addr  = 10'd0;
      lk_len   = 8'd0;
      lk_patch = 1'b0;
      case (req_type)
         8'd1: begin
            lk_hit  = 1'b1;
            lk_addr = i_desc_dev_addr;
            lk_len  = i_desc_dev_len;
         end
         8'd6: begin
            lk_hit  = 1'b1;
            lk_addr = i_desc_qual_addr;
            lk_len  = i_desc_qual_len;
         end
         8'd2: begin
            lk_hit  = 1'b1;
            lk_addr = req_hs ? i_desc_hscfg_addr : i_desc_fscfg_addr;
            lk_len  = req_hs ? i_desc_hscfg_len  : i_desc_fscfg_len;
         end
         8'd7: begin
            // Other-speed config reuses the opposite-speed window with its type byte rewritten.
            lk_hit   = 1'b1;
            lk_patch = 1'b1;
            lk_addr  = req_hs ? i_desc_fscfg_addr : i_desc_hscfg_addr;
            lk_len   = req_hs ? i_desc_fscfg_len  : i_desc_hscfg_len;
         end
         8'd3: begin
            if (i_descrom_have_strings) begin
               case (req_index)
                  8'd0: begin
                     lk_hit  = 1'b1;
                     lk_addr = i_desc_strlang_addr;
                     lk_len  = 8'(LANG_LEN);
                  end
                  8'd1: begin
                     lk_hit  = 1'b1;
                     lk_addr = i_desc_strvendor_addr;
                     lk_len  = i_desc_strvendor_len;
                  end
                  8'd2: begin
                     lk_hit  = 1'b1;
                     lk_addr = i_desc_strproduct_addr;
                     lk_len  = i_desc_strproduct_len;
                  end
                  8'd3: begin
                     lk_hit  = 1'b1;
                     lk_addr = i_desc_strserial_addr;
                     lk_len  = i_desc_strserial_len;
                  end
                  default: ;
               endcase
            end
         end
         default: ;
      endcase
   end

   assign lk_ok      = lk_hit && (lk_len != 8'd0);
   assign lk_len16   = {8'd0, lk_len};
   assign lk_total   = (lk_len16 < req_wlength) ? lk_len16 : req_wlength;

   assign fire       = (state == S_SEND) && i_tx_ready;
   assign last_byte  = (pkt_cnt == PKT_W'(MAXPKT - 1)) || (sent == total - 16'd1);
   assign more       = (sent < total);
   assign zlp_needed = (total[PKT_W-1:0] == '0) && (total < req_wlength);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (i_abort) begin
         state_nxt = S_IDLE;
      end else if (i_start) begin
         state_nxt = S_LOOKUP;
      end else begin
         case (state)
            S_LOOKUP: begin
               if (!lk_ok)                 state_nxt = S_STALL;
               else if (lk_total == 16'd0) state_nxt = S_ZLP;
               else                        state_nxt = S_SEND;
            end
            S_SEND: begin
               if (fire && last_byte) state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (i_pkt_ack) begin
                  if (more)            state_nxt = S_SEND;
                  else if (zlp_needed) state_nxt = S_ZLP;
                  else                 state_nxt = S_IDLE;
               end
`ifdef USB_DESC_RETRY_EN
               else if (i_pkt_nak) begin
                  state_nxt = S_SEND;
               end
`endif
            end
            S_ZLP: begin
               state_nxt = S_ZLP_WAIT;
            end
            S_ZLP_WAIT: begin
               if (i_pkt_ack) begin
                  state_nxt = S_IDLE;
               end
`ifdef USB_DESC_RETRY_EN
               else if (i_pkt_nak) begin
                  state_nxt = S_ZLP;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_type    <= 8'd0;
         req_index   <= 8'd0;
         req_wlength <= 16'd0;
         req_hs      <= 1'b0;
         ptr         <= 10'd0;
         sent        <= 16'd0;
         total       <= 16'd0;
         pkt_cnt     <= '0;
         patch       <= 1'b0;
`ifdef USB_DESC_RETRY_EN
         save_ptr    <= 10'd0;
         save_sent   <= 16'd0;
`endif
      end else if (i_abort) begin
         ptr     <= 10'd0;
         sent    <= 16'd0;
         total   <= 16'd0;
         pkt_cnt <= '0;
         patch   <= 1'b0;
      end else if (i_start) begin
         req_type    <= i_desc_type;
         req_index   <= i_desc_index;
         req_wlength <= i_wlength;
         req_hs      <= i_hs_mode;
         ptr         <= 10'd0;
         sent        <= 16'd0;
         pkt_cnt     <= '0;
         patch       <= 1'b0;
      end else begin
         case (state)
            S_LOOKUP: begin
               ptr     <= lk_addr;
               total   <= lk_total;
               patch   <= lk_patch;
               sent    <= 16'd0;
               pkt_cnt <= '0;
`ifdef USB_DESC_RETRY_EN
               save_ptr  <= lk_addr;
               save_sent <= 16'd0;
`endif
            end
            S_SEND: begin
               if (fire) begin
                  ptr     <= ptr + 10'd1;
                  sent    <= sent + 16'd1;
                  pkt_cnt <= pkt_cnt + PKT_W'(1);
               end
            end
            S_WAIT_ACK: begin
               if (i_pkt_ack) begin
                  pkt_cnt <= '0;
`ifdef USB_DESC_RETRY_EN
                  save_ptr  <= ptr;
                  save_sent <= sent;
`endif
               end
`ifdef USB_DESC_RETRY_EN
               else if (i_pkt_nak) begin
                  ptr     <= save_ptr;
                  sent    <= save_sent;
                  pkt_cnt <= '0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign o_descrom_raddr = ptr;
   assign o_tx_valid      = (state == S_SEND);
   assign o_tx_data       = !o_tx_valid             ? 8'd0 :
                            (patch && sent == 16'd1) ? 8'h07 : i_descrom_rdat;
   assign o_tx_last       = o_tx_valid && last_byte;
   assign o_tx_zlp        = (state == S_ZLP);
   assign o_stall         = (state == S_STALL);
   assign o_busy          = (state != S_IDLE);

endmodule
`default_nettype wire
